// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//
// Bundles everything that passes between the datapath and the hazard
// controller: the pipeline latch fields and cache hit strobes the controller
// looks at, and the latch enables/flushes and PC enable it hands back.
//
// Parameters:
//   REGW        register-select width of the rs/rt/wsel fields
//
// Signals (datapath -> controller):
//   ihit        I-cache returned the instruction this cycle
//   dhit        D-cache completed the MEM-stage access this cycle
//   ifid_rs     rs field of the IF/ID instruction
//   ifid_rt     rt field of the IF/ID instruction
//   idex_dren   load sitting in EX
//   idex_wsel   destination register of the instruction in EX
//   exmem_dren  load sitting in MEM
//   exmem_dwen  store sitting in MEM
//   exmem_halt  halt instruction sitting in MEM
//   take_branch MEM-stage redirect (taken branch, j, jal, jr)
//
// Signals (controller -> datapath):
//   pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
//   exmem_en, exmem_flush, memwb_en, halt
//
// Modports:
//   master      datapath side (drives latch fields, receives controls)
//   slave       controller side
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
    parameter int REGW = 5
);
    logic            ihit;
    logic            dhit;
    logic [REGW-1:0] ifid_rs;
    logic [REGW-1:0] ifid_rt;
    logic            idex_dren;
    logic [REGW-1:0] idex_wsel;
    logic            exmem_dren;
    logic            exmem_dwen;
    logic            exmem_halt;
    logic            take_branch;

    logic            pc_en;
    logic            ifid_en;
    logic            ifid_flush;
    logic            idex_en;
    logic            idex_flush;
    logic            exmem_en;
    logic            exmem_flush;
    logic            memwb_en;
    logic            halt;

    modport master (
        output ihit, dhit, ifid_rs, ifid_rt, idex_dren, idex_wsel,
               exmem_dren, exmem_dwen, exmem_halt, take_branch,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, exmem_flush, memwb_en, halt
    );

    modport slave (
        input  ihit, dhit, ifid_rs, ifid_rt, idex_dren, idex_wsel,
               exmem_dren, exmem_dwen, exmem_halt, take_branch,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, exmem_flush, memwb_en, halt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Control-side counterpart of the four pipeline latches (IF/ID, ID/EX,
// EX/MEM, MEM/WB). Looks at the latch outputs and cache hit strobes and
// produces every latch enable/flush plus the PC enable, resolving I-cache
// misses, D-cache waits, load-use hazards and taken redirects, and
// sequencing the drain that follows a halt instruction.
//
// All hazard decisions are combinational: a hazard seen this cycle shapes
// the enables of this same cycle. The only state is the RUN/HDRAIN/HALTED
// sequencer (and the optional counters).
//
// Parameters:
//   REGW        register-select width
//   CNT_W       performance counter width (only with HAZARD_PERF_CNT_EN)
//
// Ports:
//   CLK         clock, rising edge
//   nRST        asynchronous active-low reset
//   hz          pipe_hazard_ctrl_if.slave, latch fields in / controls out
//   stall_cnt   load-use stall cycles        (HAZARD_PERF_CNT_EN only)
//   flush_cnt   redirect flush cycles        (HAZARD_PERF_CNT_EN only)
//   miss_cnt    D-wait plus I-miss cycles    (HAZARD_PERF_CNT_EN only)
//
// Optional feature macro: HAZARD_PERF_CNT_EN adds the three saturating
// performance counters. Without it the counters and their ports are absent.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int REGW  = 5,
    parameter int CNT_W = 16
) (
    input  logic               CLK,
    input  logic               nRST,
    pipe_hazard_ctrl_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt,
    output logic [CNT_W-1:0]   miss_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HDRAIN = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic memwait;
    logic loaduse;

    logic in_run;
    logic rule_halt;
    logic rule_wait;
    logic rule_branch;
    logic rule_loaduse;
    logic rule_imiss;
    logic rule_normal;

    // Counter widths below one bit make no sense; this empty block only
    // exists so a bad CNT_W is visible at elaboration.
    if (CNT_W < 1) begin : g_bad_cnt_w
    end

    // A memory op in MEM that the D-cache has not finished yet.
    assign memwait = (hz.exmem_dren | hz.exmem_dwen) & ~hz.dhit;

    // Load in EX whose destination is a source of the instruction in ID.
    // Register zero is hardwired, so writes to it never create a hazard.
    assign loaduse = hz.idex_dren
                   & (hz.idex_wsel != {REGW{1'b0}})
                   & ((hz.idex_wsel == hz.ifid_rs) | (hz.idex_wsel == hz.ifid_rt));

    // Resolve which single RUN rule is active this cycle. Exactly one of
    // the rule_* flags is high while running, none outside RUN. Both the
    // output logic and the counters key off these flags so they can never
    // disagree about which hazard won.
    always_comb begin
        in_run       = (state == RUN);
        rule_halt    = in_run & hz.exmem_halt & ~memwait;
        rule_wait    = in_run & memwait;
        rule_branch  = in_run & ~rule_halt & ~memwait & hz.take_branch;
        rule_loaduse = in_run & ~rule_halt & ~memwait & ~hz.take_branch & loaduse;
        rule_imiss   = in_run & ~rule_halt & ~memwait & ~hz.take_branch & ~loaduse
                     & ~hz.ihit;
        rule_normal  = in_run & ~rule_halt & ~memwait & ~hz.take_branch & ~loaduse
                     & hz.ihit;
    end

    // Sequencer state register; reset always lands back in RUN so any
    // stall or drain in progress is simply abandoned.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: a halt that reaches MEM with no pending memory wait
    // starts a one-cycle drain, after which the core stays halted until
    // reset.
    always_comb begin
        next_state = state;
        case (state)
            RUN:     if (rule_halt) next_state = HDRAIN;
            HDRAIN:  next_state = HALTED;
            HALTED:  next_state = HALTED;
            default: next_state = RUN;
        endcase
    end

    // Output decode. Everything is forced low while reset is held. A
    // flushed latch still gets its enable so the bubble is actually
    // clocked in; flush takes priority inside the latch itself.
    always_comb begin
        hz.pc_en       = 1'b0;
        hz.ifid_en     = 1'b0;
        hz.ifid_flush  = 1'b0;
        hz.idex_en     = 1'b0;
        hz.idex_flush  = 1'b0;
        hz.exmem_en    = 1'b0;
        hz.exmem_flush = 1'b0;
        hz.memwb_en    = 1'b0;
        hz.halt        = 1'b0;

        if (nRST) begin
            case (state)
                RUN: begin
                    if (rule_halt) begin
                        // Let only the halt itself move into WB.
                        hz.memwb_en = 1'b1;
                    end else if (rule_wait) begin
                        // Full freeze; nothing else may advance.
                    end else if (rule_branch) begin
                        // Redirect wins even over a missing fetch: the
                        // wrong-path instructions in IF/ID, ID/EX and
                        // EX/MEM are all squashed.
                        hz.pc_en       = 1'b1;
                        hz.ifid_en     = 1'b1;
                        hz.ifid_flush  = 1'b1;
                        hz.idex_en     = 1'b1;
                        hz.idex_flush  = 1'b1;
                        hz.exmem_en    = 1'b1;
                        hz.exmem_flush = 1'b1;
                        hz.memwb_en    = 1'b1;
                    end else if (rule_loaduse) begin
                        // Hold the consumer in ID and insert a bubble
                        // behind the load. IF/ID is held, not flushed,
                        // even if the I-cache missed this cycle.
                        hz.idex_en     = 1'b1;
                        hz.idex_flush  = 1'b1;
                        hz.exmem_en    = 1'b1;
                        hz.memwb_en    = 1'b1;
                    end else if (rule_imiss) begin
                        // Keep the PC, feed a bubble into IF/ID and let
                        // the older instructions drain forward.
                        hz.ifid_en     = 1'b1;
                        hz.ifid_flush  = 1'b1;
                        hz.idex_en     = 1'b1;
                        hz.exmem_en    = 1'b1;
                        hz.memwb_en    = 1'b1;
                    end else if (rule_normal) begin
                        hz.pc_en       = 1'b1;
                        hz.ifid_en     = 1'b1;
                        hz.idex_en     = 1'b1;
                        hz.exmem_en    = 1'b1;
                        hz.memwb_en    = 1'b1;
                    end
                end
                HDRAIN: begin
                    // One dead cycle while the halt retires from WB.
                end
                HALTED: begin
                    hz.halt = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Saturating performance counters. They only move on RUN rules, so
    // they naturally freeze once the halt drain starts.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            miss_cnt  <= '0;
        end else begin
            if (rule_loaduse && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (rule_branch && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
            if ((rule_wait || rule_imiss) && (miss_cnt != {CNT_W{1'b1}})) begin
                miss_cnt <= miss_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl. A behavioural model derives the
// expected controls from the hazard priority list each cycle; literal
// expectations after each directed vector pin that model down.
// Compile with HAZARD_PERF_CNT_EN to also exercise the counters (CNT_W=4).
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int REGW = 5;
`ifdef HAZARD_PERF_CNT_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 16;
`endif

    logic CLK = 1'b0;
    logic nRST = 1'b0;

    int checks = 0;
    int errors = 0;

    // Cycles elapsed since the model accepted a halt into WB; -1 = none.
    int haltAge = -1;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] miss_cnt;
    int mStall = 0;
    int mFlush = 0;
    int mMiss  = 0;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`endif

    // Free-running clock, 10 time-unit period.
    always #5 CLK = ~CLK;

    pipe_hazard_ctrl_if #(.REGW(REGW)) hz ();

    pipe_hazard_ctrl #(
        .REGW  (REGW),
        .CNT_W (CNT_W)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .hz        (hz)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    // Drive one vector right after the rising edge, then settle at the
    // following falling edge (plus a little) so callers can check it.
    task automatic applyStimulus(input logic ih, input logic dh,
                                 input logic [REGW-1:0] rs, input logic [REGW-1:0] rt,
                                 input logic idr, input logic [REGW-1:0] ws,
                                 input logic edr, input logic edw,
                                 input logic eh, input logic br);
        @(posedge CLK);
        #1;
        hz.ihit        = ih;
        hz.dhit        = dh;
        hz.ifid_rs     = rs;
        hz.ifid_rt     = rt;
        hz.idex_dren   = idr;
        hz.idex_wsel   = ws;
        hz.exmem_dren  = edr;
        hz.exmem_dwen  = edw;
        hz.exmem_halt  = eh;
        hz.take_branch = br;
        @(negedge CLK);
        #1;
    endtask

    // One literal comparison.
    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Plain cycle with nothing going on.
    task automatic idleCycle();
        applyStimulus(1'b1, 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Pulse reset for one cycle, checking the controls stay dark meanwhile.
    task automatic resetPulse(input string tag);
        @(posedge CLK);
        #1;
        nRST = 1'b0;
        #1;
        checkOutput({tag, "_halt"}, hz.halt, 1'b0);
        checkOutput({tag, "_pc_en"}, hz.pc_en, 1'b0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    initial begin
        hz.ihit        = 1'b1;
        hz.dhit        = 1'b0;
        hz.ifid_rs     = '0;
        hz.ifid_rt     = '0;
        hz.idex_dren   = 1'b0;
        hz.idex_wsel   = '0;
        hz.exmem_dren  = 1'b0;
        hz.exmem_dwen  = 1'b0;
        hz.exmem_halt  = 1'b0;
        hz.take_branch = 1'b0;

        // Behavioural model and per-cycle compare. Output vector order:
        // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
        //  exmem_en, exmem_flush, memwb_en, halt}.
        // The enable of a latch that is being flushed is a don't-care.
        fork
            forever begin
                logic [8:0] act;
                logic [8:0] expv;
                logic [8:0] care;
                logic mw;
                logic lu;
                int rule;
                @(negedge CLK);
                act  = {hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_en, hz.idex_flush,
                        hz.exmem_en, hz.exmem_flush, hz.memwb_en, hz.halt};
                care = 9'h1FF;
                rule = 0;
                mw = (hz.exmem_dren || hz.exmem_dwen) && !hz.dhit;
                lu = hz.idex_dren && (hz.idex_wsel != 0) &&
                     ((hz.idex_wsel == hz.ifid_rs) || (hz.idex_wsel == hz.ifid_rt));
                if (!nRST) begin
                    expv = 9'b0;
                    haltAge = -1;
`ifdef HAZARD_PERF_CNT_EN
                    mStall = 0;
                    mFlush = 0;
                    mMiss  = 0;
`endif
                end else if (haltAge == 1) begin
                    expv = 9'b0;
                end else if (haltAge >= 2) begin
                    expv = 9'b000000001;
                end else if (hz.exmem_halt && !mw) begin
                    expv = 9'b000000010;
                    rule = 1;
                end else if (mw) begin
                    expv = 9'b0;
                    rule = 2;
                end else if (hz.take_branch) begin
                    expv = 9'b111111110;
                    care = 9'b101010111;
                    rule = 3;
                end else if (lu) begin
                    expv = 9'b000011010;
                    care = 9'b111011111;
                    rule = 4;
                end else if (!hz.ihit) begin
                    expv = 9'b011101010;
                    care = 9'b101111111;
                    rule = 5;
                end else begin
                    expv = 9'b110101010;
                    rule = 6;
                end

                checks++;
                if ((act & care) !== (expv & care)) begin
                    errors++;
                    $display("[TB] FAIL cycle_outputs: got %b, expected %b (care %b) at t=%0t",
                             act, expv, care, $time);
                end

`ifdef HAZARD_PERF_CNT_EN
                checks++;
                if ({stall_cnt, flush_cnt, miss_cnt} !==
                    {CNT_W'(mStall), CNT_W'(mFlush), CNT_W'(mMiss)}) begin
                    errors++;
                    $display("[TB] FAIL cycle_counters: got %0d/%0d/%0d, expected %0d/%0d/%0d at t=%0t",
                             stall_cnt, flush_cnt, miss_cnt, mStall, mFlush, mMiss, $time);
                end
                if (rule == 4 && mStall < CNT_MAX) mStall++;
                if (rule == 3 && mFlush < CNT_MAX) mFlush++;
                if ((rule == 2 || rule == 5) && mMiss < CNT_MAX) mMiss++;
`endif

                // Advance the halt bookkeeping for the next cycle.
                if (nRST) begin
                    if (rule == 1) haltAge = 1;
                    else if (haltAge >= 1 && haltAge < 100) haltAge++;
                end
            end
        join_none

        // Reset values.
        @(negedge CLK);
        #1;
        checkOutput("reset_pc_en", hz.pc_en, 1'b0);
        checkOutput("reset_memwb_en", hz.memwb_en, 1'b0);
        checkOutput("reset_halt", hz.halt, 1'b0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        // Normal flow.
        idleCycle();
        checkOutput("run_pc_en", hz.pc_en, 1'b1);
        checkOutput("run_ifid_en", hz.ifid_en, 1'b1);

        // Load-use on rs, then the same pattern with wsel = 0, then on rt.
        applyStimulus(1'b1, 1'b0, 5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_pc_en", hz.pc_en, 1'b0);
        checkOutput("lu_ifid_en", hz.ifid_en, 1'b0);
        checkOutput("lu_idex_flush", hz.idex_flush, 1'b1);
        checkOutput("lu_exmem_en", hz.exmem_en, 1'b1);
        applyStimulus(1'b1, 1'b0, 5'd0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_r0_pc_en", hz.pc_en, 1'b1);
        checkOutput("lu_r0_idex_flush", hz.idex_flush, 1'b0);
        applyStimulus(1'b1, 1'b0, 5'd4, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lu_rt_ifid_en", hz.ifid_en, 1'b0);

        // D-cache wait for three cycles (branch in the middle ignored),
        // then the hit releases the pipe.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, (i == 1));
            checkOutput("dwait_pc_en", hz.pc_en, 1'b0);
            checkOutput("dwait_memwb_en", hz.memwb_en, 1'b0);
            checkOutput("dwait_exmem_flush", hz.exmem_flush, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("dhit_pc_en", hz.pc_en, 1'b1);
        checkOutput("dhit_memwb_en", hz.memwb_en, 1'b1);
        applyStimulus(1'b1, 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("swait_idex_en", hz.idex_en, 1'b0);

        // Branch wins over both an I-miss and a load-use.
        applyStimulus(1'b0, 1'b0, 5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("br_pc_en", hz.pc_en, 1'b1);
        checkOutput("br_ifid_flush", hz.ifid_flush, 1'b1);
        checkOutput("br_idex_flush", hz.idex_flush, 1'b1);
        checkOutput("br_exmem_flush", hz.exmem_flush, 1'b1);
        checkOutput("br_memwb_en", hz.memwb_en, 1'b1);

        // I-miss alone, then I-miss together with load-use.
        applyStimulus(1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("imiss_pc_en", hz.pc_en, 1'b0);
        checkOutput("imiss_ifid_flush", hz.ifid_flush, 1'b1);
        checkOutput("imiss_idex_en", hz.idex_en, 1'b1);
        applyStimulus(1'b0, 1'b0, 5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("imiss_lu_ifid_en", hz.ifid_en, 1'b0);
        checkOutput("imiss_lu_ifid_flush", hz.ifid_flush, 1'b0);

        // Halt: accept, one dead cycle, then halted for good.
        applyStimulus(1'b1, 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("halt_acc_memwb_en", hz.memwb_en, 1'b1);
        checkOutput("halt_acc_pc_en", hz.pc_en, 1'b0);
        checkOutput("halt_acc_exmem_en", hz.exmem_en, 1'b0);
        idleCycle();
        checkOutput("hdrain_memwb_en", hz.memwb_en, 1'b0);
        checkOutput("hdrain_halt", hz.halt, 1'b0);
        idleCycle();
        checkOutput("halted_halt", hz.halt, 1'b1);
        checkOutput("halted_pc_en", hz.pc_en, 1'b0);
        applyStimulus(1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("halted_sticky", hz.halt, 1'b1);
        checkOutput("halted_no_flush", hz.ifid_flush, 1'b0);
        resetPulse("rst_halted");
        idleCycle();
        checkOutput("after_rst_pc_en", hz.pc_en, 1'b1);

        // Halt blocked by a pending load, then accepted on the hit; reset
        // lands in the middle of the drain cycle.
        applyStimulus(1'b1, 1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("halt_wait_memwb_en", hz.memwb_en, 1'b0);
        applyStimulus(1'b1, 1'b1, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("halt_hit_memwb_en", hz.memwb_en, 1'b1);
        @(posedge CLK);
        #2;
        hz.exmem_halt = 1'b0;
        hz.exmem_dren = 1'b0;
        #1;
        checkOutput("mid_drain_memwb_en", hz.memwb_en, 1'b0);
        nRST = 1'b0;
        #1;
        checkOutput("mid_drain_rst_halt", hz.halt, 1'b0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        idleCycle();
        checkOutput("drain_rst_pc_en", hz.pc_en, 1'b1);
        idleCycle();
        checkOutput("drain_rst_no_halt", hz.halt, 1'b0);

`ifdef HAZARD_PERF_CNT_EN
        // Twenty load-use cycles saturate a 4-bit stall counter.
        resetPulse("rst_cnt");
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0, 5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        idleCycle();
        checks++;
        if (stall_cnt !== 4'd15) begin
            errors++;
            $display("[TB] FAIL stall_cnt_sat: got %0d, expected 15", stall_cnt);
        end
`endif

        idleCycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
